// File: rtl/x_par16_chk.sv
// x_par16_chk: sequential parity-check stage around an external 16-input XOR cell.
// Optional WORD_CNT output when X_PAR16_WORD_CNT_EN is defined.
//
// Ports:
//   CLK, RSTN             clock, asynchronous active-low reset
//   DIN_VALID/DIN_READY   word handshake (ready only while idle)
//   DIN, DIN_PAR          data word and its expected parity bit
//   XOR_I, XOR_O          registered word to the XOR cell, cell output back
//   RES_VALID, RES_ERR    one-cycle result strobe and held mismatch flag
//   ERR_CNT, ERR_STICKY   saturating mismatch count and sticky flag
//   CLR                   synchronous clear of ERR_CNT/ERR_STICKY (and WORD_CNT)
//   WORD_CNT              (X_PAR16_WORD_CNT_EN only) wrapping capture count
module x_par16_chk #(
    parameter int SETTLE_CYC  = 2,
    parameter int ERR_CNT_W   = 8,
    parameter bit EVEN_PARITY = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 DIN_VALID,
    output logic                 DIN_READY,
    input  logic [15:0]          DIN,
    input  logic                 DIN_PAR,
    output logic [15:0]          XOR_I,
    input  logic                 XOR_O,
    output logic                 RES_VALID,
    output logic                 RES_ERR,
    output logic [ERR_CNT_W-1:0] ERR_CNT,
    output logic                 ERR_STICKY,
    input  logic                 CLR
`ifdef X_PAR16_WORD_CNT_EN
    ,
    output logic [31:0]          WORD_CNT
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       par_r;
    logic       accept;
    logic       capture;
    logic       err;
    logic       cap_err;

    // State register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; unused encodings fall back to idle
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (DIN_VALID) begin
                    state_nxt = ST_SETTLE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_SETTLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        DIN_READY = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE:   DIN_READY = 1'b1;
            ST_SETTLE: capture   = (cnt == 4'd0);
            default: begin
                DIN_READY = 1'b0;
                capture   = 1'b0;
            end
        endcase
    end

    assign accept = DIN_READY & DIN_VALID;

    // XOR_O is the parity of the word; combined with the expected bit the
    // total is odd on mismatch for even parity, even on mismatch for odd.
    assign err     = (XOR_O ^ par_r) ^ ~EVEN_PARITY;
    assign cap_err = capture & err;

    // Word capture and settle counter
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            XOR_I <= 16'h0000;
            par_r <= 1'b0;
            cnt   <= 4'd0;
        end else begin
            if (accept) begin
                XOR_I <= DIN;
                par_r <= DIN_PAR;
                cnt   <= CNT_INIT;
            end else if (state == ST_SETTLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Result strobe; RES_ERR holds until the next capture
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            RES_VALID <= 1'b0;
            RES_ERR   <= 1'b0;
        end else begin
            RES_VALID <= capture;
            if (capture) begin
                RES_ERR <= err;
            end
        end
    end

    // Error statistics: a clear on a failing capture edge leaves a count of one
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ERR_CNT    <= '0;
            ERR_STICKY <= 1'b0;
        end else if (CLR) begin
            ERR_CNT    <= cap_err ? CNT_ONE : '0;
            ERR_STICKY <= cap_err;
        end else if (cap_err) begin
            ERR_STICKY <= 1'b1;
            if (ERR_CNT != CNT_MAX) begin
                ERR_CNT <= ERR_CNT + CNT_ONE;
            end
        end
    end

`ifdef X_PAR16_WORD_CNT_EN
    // Capture count, pass or fail, wrapping
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            WORD_CNT <= 32'd0;
        end else if (CLR) begin
            WORD_CNT <= capture ? 32'd1 : 32'd0;
        end else if (capture) begin
            WORD_CNT <= WORD_CNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_x_par16_chk.sv
// tb_x_par16_chk: scoreboard bench for x_par16_chk with an inline XOR cell.
// Predictor pushes expected results on accept; monitor pops on result strobes.
module tb_x_par16_chk;

    localparam int SETTLE = 3;
    localparam int CW     = 4;
    localparam bit EVEN   = 1'b1;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [15:0]   din = 16'h0;
    logic          din_par = 1'b0;
    logic [15:0]   xor_i;
    logic          xor_o;
    logic          res_valid;
    logic          res_err;
    logic [CW-1:0] err_cnt;
    logic          err_sticky;
    logic          clr = 1'b0;
`ifdef X_PAR16_WORD_CNT_EN
    logic [31:0]   word_cnt;
`endif

    x_par16_chk #(
        .SETTLE_CYC (SETTLE),
        .ERR_CNT_W  (CW),
        .EVEN_PARITY(EVEN)
    ) dut (
        .CLK       (clk),
        .RSTN      (rstn),
        .DIN_VALID (din_valid),
        .DIN_READY (din_ready),
        .DIN       (din),
        .DIN_PAR   (din_par),
        .XOR_I     (xor_i),
        .XOR_O     (xor_o),
        .RES_VALID (res_valid),
        .RES_ERR   (res_err),
        .ERR_CNT   (err_cnt),
        .ERR_STICKY(err_sticky),
        .CLR       (clr)
`ifdef X_PAR16_WORD_CNT_EN
        ,
        .WORD_CNT  (word_cnt)
`endif
    );

    always #5 clk = ~clk;

    // 16-input XOR cell
    assign xor_o = ^xor_i;

    typedef struct {
        logic err;
        int   due;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          busy_until = 0;
    int          cnt_m = 0;
    logic        sticky_m = 1'b0;
    logic [15:0] xor_exp = 16'h0;
    logic        res_err_exp = 1'b0;
    bit          ready_pre;
    bit          exp_v;
    bit          b2b = 1'b0;
    int          last_acc = -1;

    function automatic logic ref_err(input logic [15:0] w, input logic p);
        int ones;
        ones = $countones({w, p});
        return EVEN ? ((ones % 2) != 0) : ((ones % 2) == 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Predictor: edge-level view of accepts, captures and statistics
    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                q.delete();
                cnt_m      = 0;
                sticky_m   = 1'b0;
                xor_exp    = 16'h0;
                busy_until = cyc;
            end else begin
                cyc++;
                ready_pre = (cyc - 1 >= busy_until);
                if (clr) begin
                    cnt_m    = 0;
                    sticky_m = 1'b0;
                end
                if (q.size() > 0 && q[0].due == cyc && q[0].err) begin
                    if (cnt_m < CMAX) cnt_m++;
                    sticky_m = 1'b1;
                end
                if (ready_pre && din_valid) begin
                    q.push_back('{err: ref_err(din, din_par), due: cyc + SETTLE});
                    xor_exp    = din;
                    busy_until = cyc + SETTLE;
                    if (b2b && last_acc >= 0)
                        chk("accept_interval", cyc - last_acc, SETTLE + 1);
                    last_acc = cyc;
                end
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle, pops on result strobes
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) res_err_exp = 1'b0;
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            chk("res_valid", res_valid, exp_v);
            if (exp_v) begin
                res_err_exp = q[0].err;
                void'(q.pop_front());
            end
            chk("res_err", res_err, res_err_exp);
            chk("err_cnt", err_cnt, cnt_m);
            chk("err_sticky", err_sticky, sticky_m);
            chk("xor_i", xor_i, xor_exp);
            chk("din_ready", din_ready, cyc >= busy_until);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (SETTLE + 2) tick();
    endtask

    task automatic send(input logic [15:0] w, input logic p);
        int n;
        din       = w;
        din_par   = p;
        din_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!din_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", din_ready, 1'b1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        send(16'h0001, 1'b1);
        drain();
        chk("p1_err", res_err, 1'b0);
        chk("p1_cnt", err_cnt, 0);
        chk("p1_sticky", err_sticky, 1'b0);

        send(16'h0003, 1'b1);
        drain();
        chk("p2_err", res_err, 1'b1);
        chk("p2_cnt", err_cnt, 1);
        chk("p2_sticky", err_sticky, 1'b1);

        send(16'hFFFF, 1'b0);
        drain();
        chk("p3_err", res_err, 1'b0);
        chk("p3_cnt", err_cnt, 1);
        chk("p3_sticky", err_sticky, 1'b1);

        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) begin
                clr = ($urandom_range(0, 7) == 0);
                tick();
            end
            clr = 1'b0;
            send(16'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();

        for (int i = 0; i < 20; i++) begin
            w = 16'($urandom);
            send(w, ~^w);
        end
        drain();
        chk("sat_cnt", err_cnt, 4'hF);
        chk("sat_sticky", err_sticky, 1'b1);

        w = 16'h0007;
        send(w, 1'b0);
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        chk("clr_cap_cnt", err_cnt, 1);
        chk("clr_cap_sticky", err_sticky, 1'b1);

        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        chk("clr_cnt", err_cnt, 0);
        chk("clr_sticky", err_sticky, 1'b0);
        tick();

        b2b      = 1'b1;
        last_acc = -1;
        for (int i = 0; i < 8; i++) begin
            send((i % 2 == 0) ? 16'hA5A5 : 16'h5A5A, 1'b0);
        end
        b2b = 1'b0;
        drain();

        send(16'h1234, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_xor_i", xor_i, 16'h0);
        chk("rst_ready", din_ready, 1'b1);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_cnt", err_cnt, 0);
        tick();
        tick();
        rstn = 1'b1;
        drain();
        send(16'h8001, 1'b1);
        drain();
        chk("post_rst_err", res_err, 1'b1);
        chk("post_rst_cnt", err_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
